// File: rtl/leds_mmio_if.sv
// Data-bus interface between the core's data port and the LED peripheral.
interface leds_mmio_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output addr, wdata, we, re,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, rvalid
    );
endinterface

// File: rtl/leds_mmio.sv
// Memory-mapped LED peripheral: CTRL/VALUE/PRESCALE/STATUS registers in a
// 16-byte window, with a prescaled tick driving static/blink/rotate/off modes.
module leds_mmio #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          LED_WIDTH      = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0500,
    parameter int          PRESC_WIDTH    = 24,
    parameter logic [PRESC_WIDTH-1:0] RESET_PRESCALE = '0
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    leds_mmio_if.slave           bus,
    output logic [LED_WIDTH-1:0] o_leds
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_VALUE    = 2'd1,
        REG_PRESCALE = 2'd2,
        REG_STATUS   = 2'd3
    } reg_sel_e;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    mode_e                  mode_q, mode_d;
    logic                   phase_q, phase_d;
    logic [LED_WIDTH-1:0]   pattern_q, pattern_d;
    logic [LED_WIDTH-1:0]   value_q, value_d;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] cnt_q;
    logic                   sticky_q;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic     hit, wr, rd;
    reg_sel_e sel;
    logic     wr_ctrl, wr_value, wr_presc;
    logic     tick, eng_tick;
    logic     unused_bits;

    assign hit = (bus.addr[ADDR_WIDTH-1:4] == BASE[ADDR_WIDTH-1:4]);
    assign sel = reg_sel_e'(bus.addr[3:2]);
    assign wr  = hit && bus.we;
    assign rd  = hit && bus.re;

    assign wr_ctrl  = wr && (sel == REG_CTRL);
    assign wr_value = wr && (sel == REG_VALUE);
    assign wr_presc = wr && (sel == REG_PRESCALE);

    // Counter tick is suppressed by CTRL/PRESCALE writes (they restart the count);
    // the pattern engine additionally loses the tick to a VALUE write.
    assign tick     = (cnt_q == presc_q) && !wr_ctrl && !wr_presc;
    assign eng_tick = tick && !wr_value;

    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    // Prescale counter: wraps after reaching PRESCALE, restarts on CTRL/PRESCALE write.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt_q <= '0;
        end else if (wr_ctrl || wr_presc || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Configuration registers; STATUS is read-only so it has no write path.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            presc_q <= RESET_PRESCALE;
        end else if (wr_presc) begin
            presc_q <= bus.wdata[PRESC_WIDTH-1:0];
        end
    end

    // Sticky tick flag: a tick coinciding with a clearing STATUS read keeps it set.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sticky_q <= 1'b0;
        end else if (tick) begin
            sticky_q <= 1'b1;
        end else if (rd && (sel == REG_STATUS)) begin
            sticky_q <= 1'b0;
        end
    end

    // Pattern engine state register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            mode_q    <= MODE_STATIC;
            phase_q   <= 1'b0;
            pattern_q <= '0;
            value_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            pattern_q <= pattern_d;
            value_q   <= value_d;
        end
    end

    // Pattern engine next state, evaluated against the post-write mode/value.
    always_comb begin
        mode_d    = mode_q;
        phase_d   = phase_q;
        pattern_d = pattern_q;
        value_d   = wr_value ? bus.wdata[LED_WIDTH-1:0] : value_q;

        if (wr_ctrl) begin
            mode_d  = mode_e'(bus.wdata[1:0]);
            phase_d = 1'b0;
        end else if (eng_tick && (mode_q == MODE_BLINK)) begin
            phase_d = ~phase_q;
        end

        case (mode_d)
            MODE_STATIC: pattern_d = value_d;
            MODE_BLINK:  pattern_d = phase_d ? '0 : value_d;
            MODE_OFF:    pattern_d = '0;
            MODE_ROTATE: begin
                if (wr_value || (wr_ctrl && (mode_q != MODE_ROTATE))) begin
                    pattern_d = value_d;
                end else if (eng_tick) begin
                    pattern_d = {pattern_q[LED_WIDTH-2:0], pattern_q[LED_WIDTH-1]};
                end
            end
            default:     pattern_d = '0;
        endcase
    end

    // Read mux over the pre-write register contents.
    always_comb begin
        rd_word = '0;
        case (sel)
            REG_CTRL:     rd_word[1:0] = mode_q;
            REG_VALUE:    rd_word[LED_WIDTH-1:0] = value_q;
            REG_PRESCALE: rd_word[PRESC_WIDTH-1:0] = presc_q;
            REG_STATUS: begin
                rd_word[0] = phase_q;
                rd_word[1] = sticky_q;
                for (int unsigned i = 0; i < LED_WIDTH; i++) begin
                    if (i + 16 < DATA_WIDTH) begin
                        rd_word[i+16] = pattern_q[i];
                    end
                end
            end
            default:      rd_word = '0;
        endcase
    end

    // Registered read response; data is forced to zero when not valid.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rdata  <= rd ? rd_word : '0;
            bus.rvalid <= rd;
        end
    end

    // LED outputs lag the pattern register by one cycle.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_leds <= '0;
        end else begin
            o_leds <= pattern_q;
        end
    end

endmodule

// File: tb/tb_leds_mmio.sv
// Self-checking bench for leds_mmio: directed scenarios plus random bus traffic,
// all compared cycle by cycle against a behavioural model of the register map.
module tb_leds_mmio;

    logic        clk;
    logic        rst_n;
    logic [15:0] o_leds;

    int n_assert = 0;
    int n_fail   = 0;

    leds_mmio_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b ();

    leds_mmio #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .LED_WIDTH     (16),
        .BASE_ADDR     (32'h0000_0500),
        .PRESC_WIDTH   (24),
        .RESET_PRESCALE(24'd0)
    ) dut (
        .i_clk   (clk),
        .i_arst_n(rst_n),
        .bus     (b),
        .o_leds  (o_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int          m_mode;
    logic [15:0] m_value;
    logic [23:0] m_presc;
    int          m_cnt;
    logic        m_phase;
    logic [15:0] m_pat;
    logic        m_sticky;
    logic [15:0] e_leds;
    logic        e_rvalid;
    logic [31:0] e_rdata;

    task automatic model_reset();
        m_mode = 0; m_value = '0; m_presc = '0; m_cnt = 0;
        m_phase = 1'b0; m_pat = '0; m_sticky = 1'b0;
        e_leds = '0; e_rvalid = 1'b0; e_rdata = '0;
    endtask

    // Advance the model across one rising edge given the inputs sampled there.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        bit hit, rdh, wc, wv, wp, tk, ptk;
        int sel, old_mode;
        hit = (a[31:4] == 28'h000_0050);
        sel = int'(a[3:2]);
        rdh = hit && r;
        wc  = hit && w && sel == 0;
        wv  = hit && w && sel == 1;
        wp  = hit && w && sel == 2;

        e_rvalid = rdh;
        e_rdata  = 0;
        if (rdh) begin
            case (sel)
                0: e_rdata = 32'(m_mode);
                1: e_rdata = {16'h0, m_value};
                2: e_rdata = {8'h0, m_presc};
                default: e_rdata = {m_pat, 14'h0, m_sticky, m_phase};
            endcase
        end
        e_leds = m_pat;

        tk  = (m_cnt == int'(m_presc)) && !wc && !wp;
        ptk = tk && !wv;
        if (tk) m_sticky = 1'b1;
        else if (rdh && sel == 3) m_sticky = 1'b0;
        m_cnt = (wc || wp || tk) ? 0 : m_cnt + 1;

        old_mode = m_mode;
        if (wc) begin m_mode = int'(d[1:0]); m_phase = 1'b0; end
        if (wv) m_value = d[15:0];
        if (wp) m_presc = d[23:0];
        if (ptk && m_mode == 1) m_phase = !m_phase;

        case (m_mode)
            0: m_pat = m_value;
            1: m_pat = m_phase ? 16'h0 : m_value;
            2: begin
                if (wv || (wc && old_mode != 2)) m_pat = m_value;
                else if (ptk) m_pat = 16'((32'(m_pat) << 1) | (32'(m_pat) >> 15));
            end
            default: m_pat = 16'h0;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        @(negedge clk);
        b.addr = a; b.wdata = d; b.we = w; b.re = r;
        @(posedge clk);
        model_step(a, d, w, r);
        #1;
        check("model_leds",   32'(o_leds),   32'(e_leds));
        check("model_rvalid", 32'(b.rvalid), 32'(e_rvalid));
        check("model_rdata",  b.rdata,       e_rdata);
    endtask

    task automatic idle();
        bus(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] rot_exp [4];
        b.addr = '0; b.wdata = '0; b.we = 1'b0; b.re = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_leds",   32'(o_leds),   32'h0);
        check("reset_rvalid", 32'(b.rvalid), 32'h0);
        check("reset_rdata",  b.rdata,       32'h0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Static mode
        bus(32'h504, 32'h0000_00A5, 1'b1, 1'b0);
        idle();
        check("static_leds", 32'(o_leds), 32'h0000_00A5);
        bus(32'h504, 32'h0, 1'b0, 1'b1);
        check("static_rvalid", 32'(b.rvalid), 32'h1);
        check("static_rdata",  b.rdata,       32'h0000_00A5);
        idle();
        check("rvalid_pulse", 32'(b.rvalid), 32'h0);

        // Blink with PRESCALE=3: toggles every 4 clocks, first toggle 4 edges after CTRL write
        bus(32'h508, 32'h3, 1'b1, 1'b0);
        bus(32'h504, 32'hFFFF, 1'b1, 1'b0);
        bus(32'h500, 32'h1, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            idle();
            check("blink_leds", 32'(o_leds), (((k - 1) / 4) % 2 == 1) ? 32'h0 : 32'hFFFF);
        end

        // Rotate with PRESCALE=0
        bus(32'h500, 32'h2, 1'b1, 1'b0);
        bus(32'h504, 32'h8001, 1'b1, 1'b0);
        bus(32'h508, 32'h0, 1'b1, 1'b0);
        rot_exp[0] = 16'h8001; rot_exp[1] = 16'h0003; rot_exp[2] = 16'h0006; rot_exp[3] = 16'h000C;
        for (int k = 0; k < 4; k++) begin
            idle();
            check("rotate_leds", 32'(o_leds), 32'(rot_exp[k]));
        end
        bus(32'h504, 32'h0F00, 1'b1, 1'b0);
        idle();
        check("rotate_load", 32'(o_leds), 32'h0F00);
        idle();
        check("rotate_after_load", 32'(o_leds), 32'h1E00);

        // Sticky flag vs STATUS read
        bus(32'h500, 32'h3, 1'b1, 1'b0);
        bus(32'h508, 32'h0, 1'b1, 1'b0);
        idle();
        bus(32'h50C, 32'h0, 1'b0, 1'b1);
        check("sticky_tick_read", 32'(b.rdata[1]), 32'h1);
        bus(32'h50C, 32'h0, 1'b0, 1'b1);
        check("sticky_held", 32'(b.rdata[1]), 32'h1);
        bus(32'h508, 32'd100, 1'b1, 1'b0);
        bus(32'h50C, 32'h0, 1'b0, 1'b1);
        check("sticky_clear_read", 32'(b.rdata[1]), 32'h1);
        bus(32'h50C, 32'h0, 1'b0, 1'b1);
        check("sticky_cleared", 32'(b.rdata[1]), 32'h0);

        // Misses and STATUS writes leave registers alone
        bus(32'h504, 32'h1234, 1'b1, 1'b0);
        bus(32'h600, 32'hBEEF, 1'b1, 1'b0);
        bus(32'h50C, 32'hFFFF_FFFF, 1'b1, 1'b0);
        bus(32'h504, 32'h0, 1'b0, 1'b1);
        check("miss_value", b.rdata, 32'h0000_1234);
        bus(32'h600, 32'h0, 1'b0, 1'b1);
        check("miss_rvalid", 32'(b.rvalid), 32'h0);
        bus(32'h50C, 32'h0, 1'b0, 1'b1);
        check("status_ro", b.rdata & 32'hFFFF_0001, 32'h0);

        // Write-then-read in the same cycle returns the old value
        bus(32'h504, 32'h5555, 1'b1, 1'b1);
        check("rw_old_value", b.rdata, 32'h0000_1234);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            logic [1:0]  sel;
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8) begin
                a = 32'h500 | {28'h0, sel, 2'($urandom_range(0, 3))};
            end else begin
                case ($urandom_range(0, 3))
                    0: a = 32'h600;
                    1: a = 32'h510;
                    2: a = 32'h4FC;
                    default: a = 32'h1000_0500;
                endcase
            end
            d = $urandom;
            if (sel == 2'd2) d = {d[31:24], 24'($urandom_range(0, 4))};
            bus(a, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of a blink count
        bus(32'h504, 32'h5A5A, 1'b1, 1'b0);
        bus(32'h508, 32'd100, 1'b1, 1'b0);
        bus(32'h500, 32'h1, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) idle();
        check("pre_reset_leds", 32'(o_leds), 32'h5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_leds",   32'(o_leds),   32'h0);
        check("async_reset_rvalid", 32'(b.rvalid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus(32'h500, 32'h0, 1'b0, 1'b1);
        check("post_reset_ctrl", b.rdata, 32'h0);
        bus(32'h508, 32'h0, 1'b0, 1'b1);
        check("post_reset_prescale", b.rdata, 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
